// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter_pkg : shared state encoding and space helper for the arbiter
// Rev 1.0
// ============================================================================
package fifo_wr_arbiter_pkg;

  localparam int unsigned ARB_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR0   = 2'b01,
    ST_WR1   = 2'b10,
    ST_STALL = 2'b11
  } arb_state_e;

  // The in-flight write has not yet been counted by the FIFO, so it consumes space here.
  function automatic logic fifo_has_space(input int unsigned count,
                                          input logic        in_flight,
                                          input int unsigned depth);
    int unsigned occ;
    occ = count + (in_flight ? 32'd1 : 32'd0);
    return occ < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// arb_rr2 : combinational two-way round-robin picker (sel=1 picks requester 1)
// Rev 1.0
// ============================================================================
module arb_rr2
  import fifo_wr_arbiter_pkg::*;
(
  input  logic e0,
  input  logic e1,
  input  logic last,
  output logic sel_valid,
  output logic sel
);

  always_comb begin
    sel_valid = e0 | e1;
    // On a tie the requester that did not win most recently goes next.
    sel       = (e0 & e1) ? ~last : e1;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : two-requester round-robin write-port arbiter for the FIFO
// Rev 1.0
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = ARB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [$clog2(DEPTH):0] data_count,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  stall,
  output logic [15:0]           wcnt0,
  output logic [15:0]           wcnt1
);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [15:0]           wcnt0_q, wcnt0_d;
  logic [15:0]           wcnt1_q, wcnt1_d;
  logic                  gnt0_q, gnt1_q, wr_en_q, stall_q;

  logic e0, e1, space, sel_valid, sel;

  // A requester's req is still high in the cycle it is granted; mask it then.
  assign e0    = req0 & (state_q != ST_WR0);
  assign e1    = req1 & (state_q != ST_WR1);
  assign space = fifo_has_space(32'(data_count), wr_en_q, DEPTH);

  arb_rr2 u_rr (
    .e0        (e0),
    .e1        (e1),
    .last      (last_q),
    .sel_valid (sel_valid),
    .sel       (sel)
  );

  always_comb begin
    state_d   = ST_IDLE;
    last_d    = last_q;
    wr_data_d = wr_data_q;
    wcnt0_d   = wcnt0_q;
    wcnt1_d   = wcnt1_q;

    if (!sel_valid) begin
      state_d = ST_IDLE;
    end else if (!space) begin
      state_d = ST_STALL;
    end else if (sel) begin
      state_d = ST_WR1;
    end else begin
      state_d = ST_WR0;
    end

    unique case (state_d)
      ST_WR0: begin
        last_d    = 1'b0;
        wr_data_d = din0;
        wcnt0_d   = wcnt0_q + 16'd1;
      end
      ST_WR1: begin
        last_d    = 1'b1;
        wr_data_d = din1;
        wcnt1_d   = wcnt1_q + 16'd1;
      end
      default: begin
        last_d = last_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      wr_data_q <= '0;
      wcnt0_q   <= '0;
      wcnt1_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_data_q <= wr_data_d;
      wcnt0_q   <= wcnt0_d;
      wcnt1_q   <= wcnt1_d;
      gnt0_q    <= (state_d == ST_WR0);
      gnt1_q    <= (state_d == ST_WR1);
      wr_en_q   <= (state_d == ST_WR0) || (state_d == ST_WR1);
      stall_q   <= (state_d == ST_STALL);
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign wr_en   = wr_en_q;
  assign stall   = stall_q;
  assign wr_data = wr_data_q;
  assign wcnt0   = wcnt0_q;
  assign wcnt1   = wcnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_arbiter : vector table, corner sequences and random model check
// Rev 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] din0 = '0, din1 = '0;
  logic [3:0]  data_count = '0;
  logic        gnt0, gnt1, wr_en, stall;
  logic [31:0] wr_data;
  logic [15:0] wcnt0, wcnt1;

  fifo_wr_arbiter #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .din0(din0), .din1(din1), .data_count(data_count),
    .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en), .wr_data(wr_data),
    .stall(stall), .wcnt0(wcnt0), .wcnt1(wcnt1)
  );

  always #5 clk = ~clk;

  wire [67:0] dut_vec = {gnt0, gnt1, wr_en, stall, wr_data, wcnt0, wcnt1};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0, r1;
    logic [31:0] d0, d1;
    logic [3:0]  dc;
    logic        g0, g1, we, st;
    logic [31:0] wd;
    logic [15:0] c0, c1;
  } vec_t;

  vec_t tbl[16];

  // Reference model: who wrote last cycle (-1 none), stall flag, last winner, data, counts.
  int          m_who;
  bit          m_stall;
  int          m_last;
  logic [31:0] m_data;
  logic [15:0] m_c0, m_c1;

  task automatic model_reset();
    m_who = -1; m_stall = 0; m_last = 1; m_data = '0; m_c0 = '0; m_c1 = '0;
  endtask

  task automatic model_step();
    bit cand0, cand1;
    int occ, w;
    cand0 = req0 && (m_who != 0);
    cand1 = req1 && (m_who != 1);
    occ   = int'(data_count) + ((m_who >= 0) ? 1 : 0);
    if (!cand0 && !cand1) begin
      m_who = -1; m_stall = 0;
    end else if (occ >= 8) begin
      m_who = -1; m_stall = 1;
    end else begin
      if (cand0 && cand1) w = 1 - m_last;
      else                w = cand0 ? 0 : 1;
      m_who = w; m_stall = 0; m_last = w;
      if (w == 0) begin m_data = din0; m_c0 = m_c0 + 16'd1; end
      else        begin m_data = din1; m_c1 = m_c1 + 16'd1; end
    end
  endtask

  function automatic logic [67:0] model_vec();
    return {(m_who == 0), (m_who == 1), (m_who >= 0), m_stall, m_data, m_c0, m_c1};
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 16'd1, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h11111111, 32'h5A5A5A5A, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 16'd1, 16'd1};
    tbl[2]  = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111, 16'd2, 16'd1};
    tbl[3]  = '{1'b1, 1'b1, 32'h33333333, 32'h22222222, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 16'd2, 16'd2};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,        32'h44444444, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 16'd2, 16'd2};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,        32'h44444444, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44444444, 16'd2, 16'd3};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,        32'h55555555, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44444444, 16'd2, 16'd3};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,        32'h55555555, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55555555, 16'd2, 16'd4};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,        32'h66666666, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55555555, 16'd2, 16'd4};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,        32'h66666666, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66666666, 16'd2, 16'd5};
    tbl[10] = '{1'b1, 1'b0, 32'h77777777, 32'h0,        4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66666666, 16'd2, 16'd5};
    tbl[11] = '{1'b1, 1'b0, 32'h77777777, 32'h0,        4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h77777777, 16'd3, 16'd5};
    tbl[12] = '{1'b0, 1'b1, 32'h0,        32'h88888888, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 16'd3, 16'd5};
    tbl[13] = '{1'b0, 1'b1, 32'h0,        32'h88888888, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 16'd3, 16'd5};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77777777, 16'd3, 16'd5};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77777777, 16'd3, 16'd5};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; din0 = 32'hA5A5A5A5; din1 = 32'h5A5A5A5A;
    @(negedge clk);
    check("reset_a", dut_vec, 68'h0);
    @(negedge clk);
    check("reset_b", dut_vec, 68'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      din0 = tbl[i].d0; din1 = tbl[i].d1;
      data_count = tbl[i].dc;
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_vec,
            {tbl[i].g0, tbl[i].g1, tbl[i].we, tbl[i].st, tbl[i].wd, tbl[i].c0, tbl[i].c1});
    end

    // Asynchronous reset while a write to requester 1 is on the bus.
    req1 = 1'b1; din1 = 32'h99999999; data_count = 4'd0;
    @(posedge clk);
    #1 check("pre_rst_wr1", {63'h0, gnt1, wr_en, wcnt1}, {63'h0, 1'b1, 1'b1, 16'd6});
    #2 reset_n = 1'b0;
    #1 check("mid_rst", dut_vec, 68'h0);
    req1 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      check($sformatf("rand%0d", n), dut_vec, model_vec());
      if (m_who == 0) begin
        req0 = 1'($urandom_range(0, 1)); din0 = $urandom;
      end else if (!req0) begin
        req0 = ($urandom_range(0, 2) == 0); if (req0) din0 = $urandom;
      end
      if (m_who == 1) begin
        req1 = 1'($urandom_range(0, 1)); din1 = $urandom;
      end else if (!req1) begin
        req1 = ($urandom_range(0, 2) == 0); if (req1) din1 = $urandom;
      end
      data_count = 4'($urandom_range(0, 8));
      model_step();
      @(negedge clk);
    end
    check("rand_final", dut_vec, model_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
